// File: rtl/sseg_display_ctrl.sv
// Hex seven-segment display controller: shadow-latched value/dp/blink mask,
// leading-zero blanking, per-digit blink, lamp test, registered pins.

module sseg_digit (
    input  logic [3:0] nib,
    input  logic       dp,
    input  logic       bmask,
    input  logic       lz_blank,
    input  logic       lamp_test,
    input  logic       blink_on,
    output logic [7:0] pat
);
    logic [6:0] glyph;

    always_comb begin
        glyph = 7'h00;
        case (nib)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h58;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            4'hF: glyph = 7'h71;
            default: glyph = 7'h00;
        endcase
    end

    always_comb begin
        pat = {dp, glyph};
        if (lamp_test)
            pat = 8'hFF;
        else if (bmask && !blink_on)
            pat = 8'h00;
        else if (lz_blank)
            pat = 8'h00;
    end
endmodule

module sseg_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    blank_lz,
    input  logic                    lamp_test,
    output logic [8*NUM_DIGITS-1:0] hex_out
);
    localparam int CW = $clog2(BLINK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);
    localparam logic [8*NUM_DIGITS-1:0] POL = {(8*NUM_DIGITS){ACTIVE_LOW}};

    logic [NUM_DIGITS-1:0][3:0] val_q;
    logic [NUM_DIGITS-1:0]      dp_q;
    logic [NUM_DIGITS-1:0]      bmask_q;
    logic [CW-1:0]              cnt;
    logic                       blink_on;
    logic [NUM_DIGITS:0]        lz;
    logic [NUM_DIGITS-1:0][7:0] pat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            val_q   <= '0;
            dp_q    <= '0;
            bmask_q <= '0;
        end else if (load) begin
            val_q   <= value;
            dp_q    <= dp_in;
            bmask_q <= blink_mask;
        end
    end

    // A load restarts the blink on-phase even when it lands on terminal count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            blink_on <= 1'b1;
        end else if (load) begin
            cnt      <= '0;
            blink_on <= 1'b1;
        end else if (cnt == CNT_LAST) begin
            cnt      <= '0;
            blink_on <= ~blink_on;
        end else begin
            cnt      <= cnt + 1'b1;
        end
    end

    // Blanking ripples down from the most significant digit until a
    // non-zero nibble or a set dp is met.
    assign lz[NUM_DIGITS] = blank_lz;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        if (i == 0) begin : g_lsd
            assign lz[0] = 1'b0;
        end else begin : g_upper
            assign lz[i] = lz[i+1] && (val_q[i] == 4'h0) && !dp_q[i];
        end

        sseg_digit u_dig (
            .nib       (val_q[i]),
            .dp        (dp_q[i]),
            .bmask     (bmask_q[i]),
            .lz_blank  (lz[i]),
            .lamp_test (lamp_test),
            .blink_on  (blink_on),
            .pat       (pat[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            hex_out <= POL;
        else
            hex_out <= pat ^ POL;
    end
endmodule
